dmem_bridge: RTL and testbench

MEM-stage data-memory bridge for the 5-stage pipelined MIPS CPU. It takes the datapath's single-cycle memory port (mem_ren, mem_wen, mem_addr, mem_dout, mem_din) and converts each access into one request/acknowledge transaction on a variable-latency data bus. While a transaction is outstanding it raises mem_stall; pipeline control uses that signal to freeze every stage. The bridge also flags misaligned and timed-out accesses.

---
 rtl/dmem_bridge_if.sv | 26 ++
 rtl/dmem_bridge.sv | 102 ++++++++++
 tb/tb_dmem_bridge.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: request/acknowledge data bus between the MEM-stage bridge
// and a variable-latency data memory.
//   bus_req   bridge -> memory  request, held until acknowledged or aborted
//   bus_we    bridge -> memory  write strobe, valid while bus_req is high
//   bus_addr  bridge -> memory  word-aligned byte address
//   bus_wdata bridge -> memory  store data
//   bus_ack   memory -> bridge  single-cycle completion strobe
//   bus_rdata memory -> bridge  load data, meaningful only with bus_ack
interface dmem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts the MEM stage's single-cycle load/store port into one
// request/acknowledge transaction on a variable-latency data bus, freezing the
// pipeline with mem_stall while the transaction is outstanding.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_ren/mem_wen load / store request from the MEM stage
//   mem_addr        byte address, mem_dout store data
//   mem_din         registered load data back to the datapath
//   mem_stall       combinational freeze for all pipeline stages
//   pipe_adv        MEM-stage instruction moves to WB at this edge
//   mem_err         one-cycle pulse: misaligned, read+write conflict, timeout
//   bus             data bus (master side)
// Parameter TIMEOUT_CYCLES (2..255): WAIT cycles without ack before abort.
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    input  logic        pipe_adv,
    output logic        mem_err,
    dmem_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       acc;

    assign acc       = mem_ren | mem_wen;
    assign mem_stall = ((state == IDLE) && acc) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            mem_din       <= 32'd0;
            mem_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_wdata <= 32'd0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (mem_addr[1:0] != 2'b00) begin
                            mem_din <= 32'd0;
                            mem_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            // A simultaneous read+write is issued as a write
                            // but still reported.
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_wen;
                            bus.bus_addr  <= {mem_addr[31:2], 2'b00};
                            bus.bus_wdata <= mem_dout;
                            cnt           <= 8'd0;
                            mem_err       <= mem_ren & mem_wen;
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // An ack in the last allowed cycle still completes normally.
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            mem_din <= bus.bus_rdata;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus.bus_req <= 1'b0;
                        mem_din     <= 32'd0;
                        mem_err     <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Held until the instruction leaves MEM so a stall from
                    // another hazard cannot re-issue the same access.
                    if (pipe_adv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: self-checking bench for dmem_bridge with a short timeout.
module tb_dmem_bridge;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        pipe_adv;
    logic        mem_err;

    dmem_bridge_if bus_if ();

    dmem_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_stall (mem_stall),
        .pipe_adv  (pipe_adv),
        .mem_err   (mem_err),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_din;

    // Observations of one access, filled by run_access.
    int          obs_stall, obs_req, obs_err;
    logic [31:0] obs_din, obs_addr, obs_wdata;
    logic        obs_we, obs_unstable;

    typedef struct packed {
        int          stall;
        int          req;
        int          err;
        logic [31:0] din;
    } exp_t;

    // Reference: lat = WAIT cycle in which the bus acks (1 = first cycle).
    function automatic exp_t model(input logic ren, input logic wen,
                                   input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic [31:0] prev, input int lat);
        exp_t e;
        int conflict;
        conflict = (ren && wen) ? 1 : 0;
        if (addr[1:0] != 2'b00) begin
            e.stall = 1; e.req = 0; e.err = 1; e.din = 32'd0;
        end else if (lat <= T) begin
            e.stall = 1 + lat; e.req = lat; e.err = conflict;
            e.din = wen ? prev : rdata;
        end else begin
            e.stall = 1 + T; e.req = T; e.err = 1 + conflict; e.din = 32'd0;
        end
        return e;
    endfunction

    // Drives one access from IDLE and acts as the bus until DONE is reached.
    // Entered just after a falling edge; leaves with the DUT sitting in DONE.
    task automatic run_access(input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] dout,
                              input logic [31:0] rdata, input int lat);
        int  waits;
        bit  seen;
        bit  done;
        waits = 0; seen = 0; done = 0;
        obs_stall = 0; obs_req = 0; obs_err = 0; obs_unstable = 1'b0;
        obs_we = 1'b0; obs_addr = 32'd0; obs_wdata = 32'd0;
        mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
        bus_if.bus_ack = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            bus_if.bus_ack = 1'b0;
            if (mem_stall) obs_stall++;
            if (mem_err)   obs_err++;
            if (bus_if.bus_req) begin
                obs_req++;
                waits++;
                if (!seen) begin
                    seen = 1; obs_we = bus_if.bus_we;
                    obs_addr = bus_if.bus_addr; obs_wdata = bus_if.bus_wdata;
                end else if (obs_we !== bus_if.bus_we || obs_addr !== bus_if.bus_addr ||
                             obs_wdata !== bus_if.bus_wdata) begin
                    obs_unstable = 1'b1;
                end
                if (waits == lat) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = rdata;
                end
            end
            if (!mem_stall) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        bus_if.bus_ack = 1'b0;
        obs_din = mem_din;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_bound: stall still %0d after 200 cycles, required 0", mem_stall);
        end
    endtask

    task automatic finish_access();
        pipe_adv = 1'b1;
        @(negedge clk);
        pipe_adv = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; pipe_adv = 1'b0;
        mem_addr = 32'd0; mem_dout = 32'd0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        model_din = 32'd0;
        checks++; if (bus_if.bus_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", bus_if.bus_req); end
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", mem_err); end
        checks++; if (mem_din !== 32'd0) begin failures++; $display("FAIL rst_din: got %h want 0", mem_din); end
        checks++; if ({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata} !== 65'd0) begin
            failures++; $display("FAIL rst_bus: got we=%b addr=%h wdata=%h want all 0",
                                 bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata);
        end
    endtask

    task automatic test_load();
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h12345678, 1);
        checks++; if (obs_req != 1) begin failures++; $display("FAIL load_req: got %0d want 1", obs_req); end
        checks++; if (obs_stall != 2) begin failures++; $display("FAIL load_stall: got %0d want 2", obs_stall); end
        checks++; if (obs_din !== 32'h12345678) begin failures++; $display("FAIL load_din: got %h want 12345678", obs_din); end
        checks++; if (obs_err != 0) begin failures++; $display("FAIL load_err: got %0d want 0", obs_err); end
        checks++; if (obs_we !== 1'b0 || obs_addr !== 32'h10) begin
            failures++; $display("FAIL load_bus: got we=%b addr=%h want we=0 addr=10", obs_we, obs_addr);
        end
        model_din = 32'h12345678;
        finish_access();
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 32'h20, 32'hCAFEBABE, 32'h0BADF00D, 3);
        checks++; if (obs_req != 3) begin failures++; $display("FAIL store_req: got %0d want 3", obs_req); end
        checks++; if (obs_stall != 4) begin failures++; $display("FAIL store_stall: got %0d want 4", obs_stall); end
        checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h20 || obs_wdata !== 32'hCAFEBABE || obs_unstable) begin
            failures++; $display("FAIL store_bus: got we=%b addr=%h wdata=%h unstable=%b want 1 20 cafebabe 0",
                                 obs_we, obs_addr, obs_wdata, obs_unstable);
        end
        checks++; if (obs_din !== model_din) begin failures++; $display("FAIL store_din: got %h want %h", obs_din, model_din); end
        checks++; if (obs_err != 0) begin failures++; $display("FAIL store_err: got %0d want 0", obs_err); end
        finish_access();
    endtask

    task automatic test_misaligned();
        run_access(1'b1, 1'b0, 32'h13, 32'h0, 32'hFFFFFFFF, 1);
        checks++; if (obs_req != 0) begin failures++; $display("FAIL mis_req: got %0d want 0", obs_req); end
        checks++; if (obs_stall != 1) begin failures++; $display("FAIL mis_stall: got %0d want 1", obs_stall); end
        checks++; if (obs_err != 1) begin failures++; $display("FAIL mis_err: got %0d want 1", obs_err); end
        checks++; if (obs_din !== 32'd0) begin failures++; $display("FAIL mis_din: got %h want 0", obs_din); end
        model_din = 32'd0;
        finish_access();
    endtask

    task automatic test_timeout();
        // Prime mem_din with a nonzero value so the abort clearing it is visible.
        run_access(1'b1, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1);
        finish_access();
        run_access(1'b1, 1'b0, 32'h34, 32'h0, 32'h11111111, 1000);
        checks++; if (obs_req != T) begin failures++; $display("FAIL to_req: got %0d want %0d", obs_req, T); end
        checks++; if (obs_stall != T + 1) begin failures++; $display("FAIL to_stall: got %0d want %0d", obs_stall, T + 1); end
        checks++; if (obs_err != 1) begin failures++; $display("FAIL to_err: got %0d want 1", obs_err); end
        checks++; if (obs_din !== 32'd0) begin failures++; $display("FAIL to_din: got %h want 0", obs_din); end
        finish_access();
        model_din = 32'd0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        checks++; if (mem_din !== 32'd0 || bus_if.bus_req !== 1'b0 || mem_err !== 1'b0 || mem_stall !== 1'b0) begin
            failures++; $display("FAIL stray_ack: got din=%h req=%b err=%b stall=%b want 0 0 0 0",
                                 mem_din, bus_if.bus_req, mem_err, mem_stall);
        end
    endtask

    task automatic test_conflict();
        run_access(1'b1, 1'b1, 32'h48, 32'h76543210, 32'h99999999, 2);
        checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'h76543210) begin
            failures++; $display("FAIL conf_bus: got we=%b wdata=%h want 1 76543210", obs_we, obs_wdata);
        end
        checks++; if (obs_err != 1 || obs_req != 2 || obs_stall != 3) begin
            failures++; $display("FAIL conf_timing: got err=%0d req=%0d stall=%0d want 1 2 3", obs_err, obs_req, obs_stall);
        end
        checks++; if (obs_din !== model_din) begin failures++; $display("FAIL conf_din: got %h want %h", obs_din, model_din); end
        finish_access();
    endtask

    task automatic test_done_hold();
        logic [31:0] rd;
        rd = $urandom;
        run_access(1'b1, 1'b0, 32'h100, 32'h0, rd, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus_if.bus_req !== 1'b0 || mem_stall !== 1'b0 || mem_din !== rd) begin
                failures++; $display("FAIL hold_%0d: got req=%b stall=%b din=%h want 0 0 %h",
                                     i, bus_if.bus_req, mem_stall, mem_din, rd);
            end
        end
        finish_access();
        rd = $urandom;
        run_access(1'b1, 1'b0, 32'h104, 32'h0, rd, 1);
        checks++; if (obs_req != 1 || obs_din !== rd) begin
            failures++; $display("FAIL hold_reissue: got req=%0d din=%h want 1 %h", obs_req, obs_din, rd);
        end
        model_din = rd;
        finish_access();
    endtask

    task automatic test_reset_mid_wait();
        mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h40;
        @(negedge clk);             // first WAIT cycle
        @(negedge clk);             // second WAIT cycle
        #1;
        checks++; if (bus_if.bus_req !== 1'b1) begin failures++; $display("FAIL rmw_req_pre: got %b want 1", bus_if.bus_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ren = 1'b0;
        #1;
        checks++; if (bus_if.bus_req !== 1'b0 || mem_stall !== 1'b0) begin
            failures++; $display("FAIL rmw_idle: got req=%b stall=%b want 0 0", bus_if.bus_req, mem_stall);
        end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        checks++; if (mem_din !== 32'd0 || bus_if.bus_req !== 1'b0 || mem_err !== 1'b0) begin
            failures++; $display("FAIL rmw_late_ack: got din=%h req=%b err=%b want 0 0 0", mem_din, bus_if.bus_req, mem_err);
        end
        model_din = 32'd0;
    endtask

    task automatic test_random();
        exp_t        e;
        logic        ren, wen;
        logic [31:0] addr, dout, rd;
        int          lat, sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            ren = (sel != 1 && sel != 3);
            wen = (sel == 1 || sel == 3 || sel == 5);
            addr = $urandom;
            addr[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            dout = $urandom; rd = $urandom;
            lat = $urandom_range(1, T + 2);
            e = model(ren, wen, addr, rd, model_din, lat);
            run_access(ren, wen, addr, dout, rd, lat);
            checks++; if (obs_stall != e.stall || obs_req != e.req || obs_err != e.err) begin
                failures++; $display("FAIL rnd%0d_timing: got stall=%0d req=%0d err=%0d want %0d %0d %0d",
                                     n, obs_stall, obs_req, obs_err, e.stall, e.req, e.err);
            end
            checks++; if (obs_din !== e.din) begin
                failures++; $display("FAIL rnd%0d_din: got %h want %h", n, obs_din, e.din);
            end
            if (e.req > 0) begin
                checks++; if (obs_we !== wen || obs_addr !== {addr[31:2], 2'b00} || obs_wdata !== dout || obs_unstable) begin
                    failures++; $display("FAIL rnd%0d_bus: got we=%b addr=%h wdata=%h unstable=%b want %b %h %h 0",
                                         n, obs_we, obs_addr, obs_wdata, obs_unstable, wen, {addr[31:2], 2'b00}, dout);
                end
            end
            model_din = e.din;
            finish_access();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_conflict();
        test_done_hold();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
